vga_scan_out: RTL and testbench



---
 rtl/vga_scan_out.sv | 115 +++++++++++
 tb/tb_vga_scan_out.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan-out reading a 256x256 RGB332 framebuffer window.
// Optional VGA_BORDER_EN draws a white outline just outside the window.
module vga_scan_out #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iReadData,
  output logic [15:0] oReadAddress,
  output logic        oHSync,
  output logic        oVSync,
  output logic [2:0]  oRed,
  output logic [2:0]  oGreen,
  output logic [1:0]  oBlue,
  output logic        oActive,
  output logic        oFrameStart
);

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_VIS);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic       tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_wrap;
  logic       v_wrap;
  logic       active;
  logic       in_window;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;

  assign h_wrap    = (hcount == H_LAST);
  assign v_wrap    = (vcount == V_LAST);
  assign active    = (hcount < H_ACT) && (vcount < V_ACT);
  assign in_window = (hcount[9:8] == 2'b00) && (vcount[9:8] == 2'b00);
  assign hsync     = !((hcount >= HS_BEG) && (hcount < HS_END));
  assign vsync     = !((vcount >= VS_BEG) && (vcount < VS_END));

  assign oReadAddress = {vcount[7:0], hcount[7:0]};

`ifdef VGA_BORDER_EN
  logic border;
  assign border = ((hcount == 10'd256) && (vcount <= 10'd256)) ||
                  ((vcount == 10'd256) && (hcount <= 10'd256));
`endif

  always_comb begin
    rgb = 8'h00;
    if (active) begin
      if (in_window)
        rgb = iReadData;
`ifdef VGA_BORDER_EN
      if (border)
        rgb = 8'hFF;
`endif
    end
  end

  // Pixel clock enable and raster counters
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tick   <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        if (h_wrap) begin
          hcount <= '0;
          vcount <= v_wrap ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Outputs describe the pixel the counters held before this tick
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oActive     <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= tick && (hcount == '0) && (vcount == '0);
      if (tick) begin
        oHSync  <= hsync;
        oVSync  <= vsync;
        oRed    <= rgb[7:5];
        oGreen  <= rgb[4:2];
        oBlue   <= rgb[1:0];
        oActive <= active;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: full-timing instance plus a
// short-frame instance so vertical behaviour fits a small run.
module tb_vga_scan_out;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [7:0]  rd_m, rd_s;
  logic [15:0] addr_m, addr_s;
  logic        hs_m, vs_m, act_m, fs_m;
  logic        hs_s, vs_s, act_s, fs_s;
  logic [2:0]  r_m, g_m, r_s, g_s;
  logic [1:0]  b_m, b_s;

  vga_scan_out dut_m (
    .Clock(clk), .Reset(rst_n), .iReadData(rd_m),
    .oReadAddress(addr_m), .oHSync(hs_m), .oVSync(vs_m),
    .oRed(r_m), .oGreen(g_m), .oBlue(b_m),
    .oActive(act_m), .oFrameStart(fs_m)
  );

  vga_scan_out #(.V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_s (
    .Clock(clk), .Reset(rst_n), .iReadData(rd_s),
    .oReadAddress(addr_s), .oHSync(hs_s), .oVSync(vs_s),
    .oRed(r_s), .oGreen(g_s), .oBlue(b_s),
    .oActive(act_s), .oFrameStart(fs_s)
  );

  // RAM model: one-clock latency, data = low address byte
  always @(posedge clk) begin
    rd_m <= addr_m[7:0];
    rd_s <= addr_s[7:0];
  end

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int    cyc;
    int    rgb;
    int    act;
    string name;
  } pix_t;

  pix_t pq[$];
  int fsq_m[$], fsq_s[$];
  int hsq[$], hwq[$], awq[$], vsq[$], vwq[$];
  int blank_bad = 0;

`ifdef VGA_BORDER_EN
  localparam int BORDER_RGB = 8'hFF;
`else
  localparam int BORDER_RGB = 8'h00;
`endif

  task automatic push_pix(int x, int y, int rgb, int act, string name);
    pix_t p;
    p.cyc  = 2 + 2 * (y * 800 + x);
    p.rgb  = rgb;
    p.act  = act;
    p.name = name;
    pq.push_back(p);
  endtask

  // Monitors
  logic prev_hs = 1'b1, prev_act = 1'b0, prev_vs = 1'b1;
  int   fall_h, rise_a, fall_v;

  always @(negedge clk) begin
    pix_t p;
    if (pq.size() > 0 && cyc == pq[0].cyc) begin
      p = pq.pop_front();
      chk({p.name, "_rgb"}, int'({r_m, g_m, b_m}), p.rgb);
      chk({p.name, "_act"}, int'(act_m), p.act);
    end
    if (fs_m) begin
      if (fsq_m.size() > 0) chk("fs_main", cyc, fsq_m.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL fs_main_extra actual pulse at %0d required none", cyc);
      end
    end
    if (fs_s) begin
      if (fsq_s.size() > 0) chk("fs_short", cyc, fsq_s.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL fs_short_extra actual pulse at %0d required none", cyc);
      end
    end
    if (prev_hs && !hs_m) begin
      fall_h = cyc;
      if (hsq.size() > 0) chk("hsync_fall", cyc, hsq.pop_front());
    end
    if (!prev_hs && hs_m && hwq.size() > 0)
      chk("hsync_low", cyc - fall_h, hwq.pop_front());
    if (!prev_act && act_m) rise_a = cyc;
    if (prev_act && !act_m && awq.size() > 0)
      chk("active_run", cyc - rise_a, awq.pop_front());
    if (prev_vs && !vs_s) begin
      fall_v = cyc;
      if (vsq.size() > 0) chk("vsync_fall", cyc, vsq.pop_front());
    end
    if (!prev_vs && vs_s && vwq.size() > 0)
      chk("vsync_low", cyc - fall_v, vwq.pop_front());
    if (!act_m && ({r_m, g_m, b_m} != 8'h00)) blank_bad++;
    if (!act_s && ({r_s, g_s, b_s} != 8'h00)) blank_bad++;
    prev_hs  = hs_m;
    prev_act = act_m;
    prev_vs  = vs_s;
  end

  task automatic check_reset(string tag);
    chk({tag, "_hs_m"}, int'(hs_m), 1);
    chk({tag, "_vs_m"}, int'(vs_m), 1);
    chk({tag, "_rgb_m"}, int'({r_m, g_m, b_m}), 0);
    chk({tag, "_act_m"}, int'(act_m), 0);
    chk({tag, "_fs_m"}, int'(fs_m), 0);
    chk({tag, "_addr_m"}, int'(addr_m), 0);
    chk({tag, "_hs_s"}, int'(hs_s), 1);
    chk({tag, "_vs_s"}, int'(vs_s), 1);
    chk({tag, "_rgb_s"}, int'({r_s, g_s, b_s}), 0);
    chk({tag, "_act_s"}, int'(act_s), 0);
    chk({tag, "_fs_s"}, int'(fs_s), 0);
    chk({tag, "_addr_s"}, int'(addr_s), 0);
  endtask

  task automatic wait_cyc(int n);
    int guard = 0;
    while (cyc != n && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++; errors++;
      $display("FAIL wait_timeout actual %0d required %0d", cyc, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("init");
    @(negedge clk);
    fsq_m.push_back(2);
    fsq_s = '{2, 16002, 32002};
    hsq = '{1314, 2914, 4514};
    hwq = '{192, 192, 192};
    awq = '{1280, 1280, 1280};
    vsq = '{9602, 25602};
    vwq = '{3200, 3200};
    push_pix(0,   0,  8'h00, 1, "p0_0");
    push_pix(639, 0,  8'h00, 1, "p639_0");
    push_pix(640, 0,  8'h00, 0, "p640_0");
    push_pix(200, 1,  8'hC8, 1, "p200_1");
    push_pix(10,  3,  {3'd0, 3'd2, 2'd2}, 1, "p10_3");
    push_pix(255, 3,  {3'd7, 3'd7, 2'd3}, 1, "p255_3");
    push_pix(256, 3,  BORDER_RGB, 1, "p256_3");
    push_pix(300, 3,  8'h00, 1, "p300_3");
    push_pix(100, 20, 8'h64, 1, "p100_20");
    rst_n = 1'b1;

    wait_cyc(32202);
    #3 rst_n = 1'b0;
    #1 check_reset("async");
    repeat (3) @(posedge clk);
    #1 check_reset("hold");
    @(negedge clk);
    fsq_m.push_back(2);
    fsq_s = '{2, 16002};
    hsq.push_back(1314);
    hwq.push_back(192);
    vsq.push_back(9602);
    vwq.push_back(3200);
    push_pix(0,   0, 8'h00, 1, "r_p0_0");
    push_pix(10,  3, 8'h0A, 1, "r_p10_3");
    push_pix(256, 3, BORDER_RGB, 1, "r_p256_3");
    rst_n = 1'b1;

    wait_cyc(16100);
    chk("pix_left", pq.size(), 0);
    chk("fs_m_left", fsq_m.size(), 0);
    chk("fs_s_left", fsq_s.size(), 0);
    chk("hs_left", hsq.size() + hwq.size(), 0);
    chk("act_left", awq.size(), 0);
    chk("vs_left", vsq.size() + vwq.size(), 0);
    chk("blanking", blank_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
